// File: rtl/pong_score_ctrl.sv
// Pong game/score controller: serve/rally sequencing, BCD scores,
// win detection and blinking score-display disable.
module pong_score_ctrl #(
    parameter logic [7:0]  WIN_SCORE  = 8'h11,
    parameter int unsigned POINT_HOLD = 25000000,
    parameter int unsigned BLINK_DIV  = 12500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       miss0,
    input  logic       miss1,
    input  logic       clr_score,
    output logic [7:0] score0,
    output logic [7:0] score1,
    output logic       serve_side,
    output logic       in_play,
    output logic       point_pulse,
    output logic       game_over,
    output logic       winner,
    output logic       dis
);

    typedef enum logic [2:0] {
        IDLE,
        SERVE,
        RALLY,
        HOLD,
        OVER
    } state_t;

    state_t      state_q;
    logic [7:0]  score0_q;
    logic [7:0]  score1_q;
    logic        side_q;
    logic        winner_q;
    logic        dis_q;
    logic        pulse_q;
    logic [31:0] hold_q;
    logic [31:0] blink_q;
    logic [7:0]  inc0_d;
    logic [7:0]  inc1_d;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r = (v[7:4] == 4'd9) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    assign inc0_d = bcd_inc(score0_q);
    assign inc1_d = bcd_inc(score1_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            score0_q <= 8'h00;
            score1_q <= 8'h00;
            side_q   <= 1'b0;
            winner_q <= 1'b0;
            dis_q    <= 1'b0;
            pulse_q  <= 1'b0;
            hold_q   <= 32'd0;
            blink_q  <= 32'd0;
        end else begin
            pulse_q <= 1'b0;
            if (clr_score) begin
                state_q  <= IDLE;
                score0_q <= 8'h00;
                score1_q <= 8'h00;
                side_q   <= 1'b0;
                winner_q <= 1'b0;
                dis_q    <= 1'b0;
                hold_q   <= 32'd0;
                blink_q  <= 32'd0;
            end else begin
                unique case (state_q)
                    IDLE: if (start) state_q <= SERVE;
                    SERVE: if (start) state_q <= RALLY;
                    RALLY: begin
                        // A double miss is a let: replay the serve unchanged
                        if (miss0 && miss1) begin
                            state_q <= SERVE;
                        end else if (miss0) begin
                            score1_q <= inc1_d;
                            pulse_q  <= 1'b1;
                            side_q   <= 1'b0;
                            if (inc1_d == WIN_SCORE) begin
                                state_q  <= OVER;
                                winner_q <= 1'b1;
                                dis_q    <= 1'b0;
                                blink_q  <= 32'd0;
                            end else begin
                                state_q <= HOLD;
                                hold_q  <= 32'd0;
                            end
                        end else if (miss1) begin
                            score0_q <= inc0_d;
                            pulse_q  <= 1'b1;
                            side_q   <= 1'b1;
                            if (inc0_d == WIN_SCORE) begin
                                state_q  <= OVER;
                                winner_q <= 1'b0;
                                dis_q    <= 1'b0;
                                blink_q  <= 32'd0;
                            end else begin
                                state_q <= HOLD;
                                hold_q  <= 32'd0;
                            end
                        end
                    end
                    HOLD: begin
                        if (hold_q == 32'(POINT_HOLD - 1)) begin
                            state_q <= SERVE;
                        end else begin
                            hold_q <= hold_q + 32'd1;
                        end
                    end
                    OVER: begin
                        if (start) begin
                            state_q  <= SERVE;
                            score0_q <= 8'h00;
                            score1_q <= 8'h00;
                            side_q   <= 1'b0;
                            winner_q <= 1'b0;
                            dis_q    <= 1'b0;
                            blink_q  <= 32'd0;
                        end else if (blink_q == 32'(BLINK_DIV - 1)) begin
                            blink_q <= 32'd0;
                            dis_q   <= ~dis_q;
                        end else begin
                            blink_q <= blink_q + 32'd1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign score0      = score0_q;
    assign score1      = score1_q;
    assign serve_side  = side_q;
    assign in_play     = (state_q == RALLY);
    assign point_pulse = pulse_q;
    assign game_over   = (state_q == OVER);
    assign winner      = winner_q;
    assign dis         = dis_q;

endmodule

// File: tb/tb_pong_score_ctrl.sv
// Scoreboard bench for pong_score_ctrl: a game-level reference model
// queues expected outputs, a monitor compares them each cycle.
module tb_pong_score_ctrl;

    localparam logic [7:0] WIN    = 8'h11;
    localparam int         WIN_D  = 11;
    localparam int         PH     = 4;
    localparam int         BD     = 3;

    localparam int P_IDLE  = 0;
    localparam int P_SERVE = 1;
    localparam int P_RALLY = 2;
    localparam int P_HOLD  = 3;
    localparam int P_OVER  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       miss0 = 1'b0;
    logic       miss1 = 1'b0;
    logic       clr_score = 1'b0;
    logic [7:0] score0;
    logic [7:0] score1;
    logic       serve_side;
    logic       in_play;
    logic       point_pulse;
    logic       game_over;
    logic       winner;
    logic       dis;

    pong_score_ctrl #(
        .WIN_SCORE (WIN),
        .POINT_HOLD(PH),
        .BLINK_DIV (BD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .miss0      (miss0),
        .miss1      (miss1),
        .clr_score  (clr_score),
        .score0     (score0),
        .score1     (score1),
        .serve_side (serve_side),
        .in_play    (in_play),
        .point_pulse(point_pulse),
        .game_over  (game_over),
        .winner     (winner),
        .dis        (dis)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    logic [21:0] q[$];

    int ph, s0, s1, hold_left, over_t;
    bit side, win, dis_m, pp;

    function automatic logic [7:0] to_bcd(input int s);
        return 8'((s / 10) * 16 + (s % 10));
    endfunction

    function logic [21:0] mvec();
        return {to_bcd(s0), to_bcd(s1), side, (ph == P_RALLY), pp,
                (ph == P_OVER), win, dis_m};
    endfunction

    function logic [21:0] avec();
        return {score0, score1, serve_side, in_play, point_pulse,
                game_over, winner, dis};
    endfunction

    task automatic m_reset();
        ph = P_IDLE; s0 = 0; s1 = 0; side = 0; win = 0;
        dis_m = 0; pp = 0; hold_left = 0; over_t = 0;
    endtask

    task automatic m_step(input bit st, input bit m0, input bit m1,
                          input bit c);
        int ns;
        bit sc;
        pp = 0;
        if (c) begin
            m_reset();
        end else begin
            case (ph)
                P_IDLE:  if (st) ph = P_SERVE;
                P_SERVE: if (st) ph = P_RALLY;
                P_RALLY: begin
                    if (m0 && m1) begin
                        ph = P_SERVE;
                    end else if (m0 || m1) begin
                        sc = m0;
                        if (sc) begin
                            s1 = (s1 + 1) % 100; ns = s1;
                        end else begin
                            s0 = (s0 + 1) % 100; ns = s0;
                        end
                        pp = 1;
                        side = ~sc;
                        if (ns == WIN_D) begin
                            ph = P_OVER; win = sc; over_t = 0; dis_m = 0;
                        end else begin
                            ph = P_HOLD; hold_left = PH;
                        end
                    end
                end
                P_HOLD: begin
                    hold_left--;
                    if (hold_left == 0) ph = P_SERVE;
                end
                P_OVER: begin
                    if (st) begin
                        s0 = 0; s1 = 0; side = 0; dis_m = 0; win = 0;
                        ph = P_SERVE;
                    end else begin
                        over_t++;
                        dis_m = ((over_t / BD) % 2) == 1;
                    end
                end
                default: ph = P_IDLE;
            endcase
        end
    endtask

    task automatic report(input string nm, input logic [21:0] a,
                          input logic [21:0] e);
        $display("FAIL %s @%0t got s0=%h s1=%h side=%b play=%b pp=%b over=%b win=%b dis=%b want s0=%h s1=%h side=%b play=%b pp=%b over=%b win=%b dis=%b",
                 nm, $time, a[21:14], a[13:6], a[5], a[4], a[3], a[2],
                 a[1], a[0], e[21:14], e[13:6], e[5], e[4], e[3], e[2],
                 e[1], e[0]);
    endtask

    task automatic cyc(input bit st, input bit m0, input bit m1,
                       input bit c);
        @(negedge clk);
        start = st; miss0 = m0; miss1 = m1; clr_score = c;
        m_step(st, m0, m1, c);
        q.push_back(mvec());
    endtask

    task automatic chk_now(input string nm);
        logic [21:0] e;
        e = mvec();
        n_chk++;
        if (avec() !== e) begin
            n_fail++;
            report(nm, avec(), e);
        end
    endtask

    // Monitor: one expected vector per clocked cycle
    always @(posedge clk) begin
        logic [21:0] e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_chk++;
            if (avec() !== e) begin
                n_fail++;
                report("out_vec", avec(), e);
            end
        end
    end

    initial begin
        m_reset();
        repeat (2) @(negedge clk);
        #1 chk_now("reset");
        rst_n = 1'b1;

        cyc(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 0, 0, 0);
            cyc(0, 0, 1, 0);
            repeat (PH) cyc(1, 1, 1, 0);
        end
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);
        repeat (8) cyc(0, 1, 1, 0);
        cyc(1, 0, 0, 0);

        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        repeat (PH) cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 1, 0);

        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 1);

        cyc(1, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            cyc(1, 0, 0, 0);
            cyc(0, 0, 1, 0);
            repeat (PH) cyc(0, 0, 0, 0);
        end
        cyc(1, 0, 0, 0);
        @(negedge clk);
        start = 0; miss0 = 0; miss1 = 0; clr_score = 0;
        rst_n = 1'b0;
        m_reset();
        #1 chk_now("async_reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0);
        end

        @(negedge clk);
        start = 0; miss0 = 0; miss1 = 0; clr_score = 0;
        @(negedge clk);
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
